// File: rtl/note_demux2_8b_if.sv
// Val/rdy bundle for the 1-to-2 note demultiplexer. It carries one input stream,
// the steering select and two output streams. The master modport is the producer/consumer side.
interface note_demux2_8b_if #(
    parameter int NBITS = 8
);
    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in_msg;
    logic             sel;

    logic             out0_val;
    logic             out0_rdy;
    logic [NBITS-1:0] out0_msg;

    logic             out1_val;
    logic             out1_rdy;
    logic [NBITS-1:0] out1_msg;

    modport master (
        output in_val, in_msg, sel, out0_rdy, out1_rdy,
        input  in_rdy, out0_val, out0_msg, out1_val, out1_msg
    );

    modport slave (
        input  in_val, in_msg, sel, out0_rdy, out1_rdy,
        output in_rdy, out0_val, out0_msg, out1_val, out1_msg
    );
endinterface

// File: rtl/note_demux2_8b.sv
// Registered 1-to-2 note demultiplexer. Each output has a one-entry buffer that passes words
// straight through, so throughput is full and latency is one cycle. Each output also has a wrapping delivery counter.
module note_demux2_8b #(
    parameter int NBITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    note_demux2_8b_if.slave        bus,
    output logic [7:0]             cnt0,
    output logic [7:0]             cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state0;
    buf_state_t       state1;
    logic [NBITS-1:0] msg0;
    logic [NBITS-1:0] msg1;

    logic deq0;
    logic deq1;
    logic target_free;
    logic xfer;
    logic enq0;
    logic enq1;

    assign deq0 = (state0 == FULL) && bus.out0_rdy;
    assign deq1 = (state1 == FULL) && bus.out1_rdy;

    // A buffer that is draining this cycle can take the next word, so there is no bubble.
    assign target_free = bus.sel ? ((state1 == EMPTY) || deq1)
                                 : ((state0 == EMPTY) || deq0);

    assign bus.in_rdy = !rst && target_free;
    assign xfer       = bus.in_val && bus.in_rdy;
    assign enq0       = xfer && !bus.sel;
    assign enq1       = xfer &&  bus.sel;

    assign bus.out0_val = (state0 == FULL);
    assign bus.out1_val = (state1 == FULL);
    assign bus.out0_msg = msg0;
    assign bus.out1_msg = msg1;

    // NOTE: sequential state uses non-blocking assignments only. Every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state0 <= EMPTY;
            state1 <= EMPTY;
            msg0   <= '0;
            msg1   <= '0;
            cnt0   <= '0;
            cnt1   <= '0;
        end else begin
            // Data registers load only on enqueue, so an idle in_msg never reaches state.
            if (enq0) begin
                state0 <= FULL;
                msg0   <= bus.in_msg;
            end else if (deq0) begin
                state0 <= EMPTY;
            end

            if (enq1) begin
                state1 <= FULL;
                msg1   <= bus.in_msg;
            end else if (deq1) begin
                state1 <= EMPTY;
            end

            if (deq0) cnt0 <= cnt0 + 8'd1;
            if (deq1) cnt1 <= cnt1 + 8'd1;
        end
    end

endmodule

// File: tb/tb_note_demux2_8b.sv
// Scoreboard bench for note_demux2_8b. Accepted words are queued per output and then compared
// when the matching output shows them. The handshake and counters are compared against a reference model each cycle.
module tb_note_demux2_8b;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    always #5 clk = ~clk;

    note_demux2_8b_if #(.NBITS(8)) bus ();

    note_demux2_8b #(.NBITS(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .cnt0 (cnt0),
        .cnt1 (cnt1)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] m_cnt0;
    logic [7:0] m_cnt1;
    bit         known = 1'b0;

    // One clock cycle. Compare at the falling edge, advance the model, then return 1 time unit after the rising edge.
    task automatic tick();
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = !rst && (bus.sel ? (q1.size() == 0 || bus.out1_rdy)
                                   : (q0.size() == 0 || bus.out0_rdy));
        tests_run++;
        if (bus.in_rdy !== exp_rdy) begin
            tests_failed++;
            $display("FAIL in_rdy t=%0t got=%b exp=%b", $time, bus.in_rdy, exp_rdy);
        end
        if (known) begin
            tests_run++;
            if (bus.out0_val !== (q0.size() != 0)) begin
                tests_failed++;
                $display("FAIL out0_val t=%0t got=%b exp=%b", $time, bus.out0_val, q0.size() != 0);
            end
            tests_run++;
            if (bus.out1_val !== (q1.size() != 0)) begin
                tests_failed++;
                $display("FAIL out1_val t=%0t got=%b exp=%b", $time, bus.out1_val, q1.size() != 0);
            end
            if (q0.size() != 0) begin
                tests_run++;
                if (bus.out0_msg !== q0[0]) begin
                    tests_failed++;
                    $display("FAIL out0_msg t=%0t got=%h exp=%h", $time, bus.out0_msg, q0[0]);
                end
            end
            if (q1.size() != 0) begin
                tests_run++;
                if (bus.out1_msg !== q1[0]) begin
                    tests_failed++;
                    $display("FAIL out1_msg t=%0t got=%h exp=%h", $time, bus.out1_msg, q1[0]);
                end
            end
            tests_run++;
            if (cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin
                tests_failed++;
                $display("FAIL counters t=%0t got=%0d/%0d exp=%0d/%0d", $time, cnt0, cnt1, m_cnt0, m_cnt1);
            end
        end
        if (rst) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 8'd0;
            m_cnt1 = 8'd0;
            known  = 1'b1;
        end else begin
            if (q0.size() != 0 && bus.out0_rdy) begin
                void'(q0.pop_front());
                m_cnt0 = m_cnt0 + 8'd1;
            end
            if (q1.size() != 0 && bus.out1_rdy) begin
                void'(q1.pop_front());
                m_cnt1 = m_cnt1 + 8'd1;
            end
            if (bus.in_val && exp_rdy) begin
                if (bus.sel) q1.push_back(bus.in_msg);
                else         q0.push_back(bus.in_msg);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_val   = 1'b1;
        bus.in_msg   = 8'hA5;
        bus.sel      = 1'b0;
        bus.out0_rdy = 1'b1;
        bus.out1_rdy = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus.out0_val !== 1'b0 || bus.out1_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_val got=%b%b exp=00", bus.out0_val, bus.out1_val);
        end
        tests_run++;
        if (bus.out0_msg !== 8'h00 || bus.out1_msg !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_msg got=%h/%h exp=00/00", bus.out0_msg, bus.out1_msg);
        end
        tests_run++;
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1);
        end
        tests_run++;
        if (bus.in_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_rdy got=%b exp=0", bus.in_rdy);
        end
        rst        = 1'b0;
        bus.in_val = 1'b0;
        #1;
        tests_run++;
        if (bus.in_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_in_rdy got=%b exp=1", bus.in_rdy);
        end
    endtask

    task automatic test_basic_steering();
        bus.in_val = 1'b1;
        bus.in_msg = 8'h11;
        bus.sel    = 1'b0;
        tick();
        bus.in_msg = 8'h22;
        bus.sel    = 1'b1;
        tick();
        bus.in_val = 1'b0;
        tick();
        tick();
        tests_run++;
        if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin
            tests_failed++;
            $display("FAIL steering_cnt got=%0d/%0d exp=1/1", cnt0, cnt1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.sel      = 1'b0;
        bus.out0_rdy = 1'b1;
        bus.in_val   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.in_msg = 8'(i);
            tick();
        end
        bus.in_val = 1'b0;
        tick();
        tick();
        tests_run++;
        if (cnt0 !== 8'd10) begin
            tests_failed++;
            $display("FAIL throughput_cnt0 got=%0d exp=10", cnt0);
        end
    endtask

    task automatic test_backpressure();
        bus.out0_rdy = 1'b0;
        bus.out1_rdy = 1'b1;
        bus.in_val   = 1'b1;
        bus.sel      = 1'b0;
        bus.in_msg   = 8'h33;
        tick();
        bus.in_msg = 8'h99;
        #1;
        tests_run++;
        if (bus.in_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL blocked_in_rdy got=%b exp=0", bus.in_rdy);
        end
        tick();
        bus.sel    = 1'b1;
        bus.in_msg = 8'h44;
        #1;
        tests_run++;
        if (bus.in_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL isolated_in_rdy got=%b exp=1", bus.in_rdy);
        end
        tick();
        bus.in_val = 1'b0;
        tests_run++;
        if (bus.out1_val !== 1'b1 || bus.out0_msg !== 8'h33) begin
            tests_failed++;
            $display("FAIL isolation got=%b/%h exp=1/33", bus.out1_val, bus.out0_msg);
        end
        tick();
        bus.out0_rdy = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus.out0_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL once_delivered got=%b exp=0", bus.out0_val);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        bus.sel      = 1'b1;
        bus.out1_rdy = 1'b1;
        bus.in_val   = 1'b1;
        for (int i = 0; i < 255; i++) begin
            bus.in_msg = 8'(i);
            tick();
        end
        bus.in_val = 1'b0;
        tick();
        tests_run++;
        if (cnt1 !== 8'd255) begin
            tests_failed++;
            $display("FAIL wrap_255 got=%0d exp=255", cnt1);
        end
        bus.in_val = 1'b1;
        bus.in_msg = 8'hFF;
        tick();
        bus.in_val = 1'b0;
        tick();
        tests_run++;
        if (cnt1 !== 8'd0 || cnt0 !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap_0 got=%0d/%0d exp=0/0", cnt1, cnt0);
        end
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 300; i++) begin
            bus.in_val   = ($urandom % 4) != 0;
            bus.sel      = 1'($urandom);
            bus.in_msg   = bus.in_val ? 8'($urandom) : 8'hxx;
            bus.out0_rdy = ($urandom % 3) != 0;
            bus.out1_rdy = ($urandom % 3) != 0;
            tick();
        end
        bus.in_val   = 1'b0;
        bus.in_msg   = 8'h00;
        bus.out0_rdy = 1'b1;
        bus.out1_rdy = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out0_rdy = 1'b0;
        bus.out1_rdy = 1'b0;
        bus.in_val   = 1'b1;
        bus.sel      = 1'b0;
        bus.in_msg   = 8'h55;
        tick();
        bus.sel    = 1'b1;
        bus.in_msg = 8'h66;
        tick();
        bus.in_val = 1'b0;
        tick();
        tests_run++;
        if (bus.out0_msg !== 8'h55 || bus.out1_msg !== 8'h66 || bus.out0_val !== 1'b1 || bus.out1_val !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_full got=%b%b %h/%h exp=11 55/66", bus.out0_val, bus.out1_val, bus.out0_msg, bus.out1_msg);
        end
        do_reset();
        tests_run++;
        if (bus.out0_val !== 1'b0 || bus.out1_val !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_reset got=%b%b %0d/%0d exp=00 0/0", bus.out0_val, bus.out1_val, cnt0, cnt1);
        end
        bus.out0_rdy = 1'b1;
        bus.out1_rdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        test_reset();
        test_basic_steering();
        test_back_to_back();
        test_backpressure();
        test_counter_wrap();
        test_random_mix();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/note_demux2_8b.md
Name: note_demux2_8b

Overview:
- Registered 1-to-2 demultiplexer for 8-bit note words; the steering counterpart to the 2:1 8-bit selection mux.
- Accepts one note stream on a val/rdy interface and routes each accepted word to output port 0 or 1 based on `sel`, sampled at acceptance.
- Each output has a one-entry buffer, giving 1-cycle latency with full throughput.
- Feeds two independent note consumers, e.g. the two tone generators of the music datapath.

Parameters:
- `NBITS`, 8, width of the note word. Counters stay 8 bits regardless of `NBITS`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_val`  in  1  input word valid.
- `in_rdy`  out  1  block can accept a word this cycle.
- `in_msg`  in  NBITS  input note word.
- `sel`  in  1  destination for the current input word; 0 selects out0, 1 selects out1.
- `out0_val`  out  1  out0 buffer holds a word.
- `out0_rdy`  in  1  consumer 0 accepts.
- `out0_msg`  out  NBITS  out0 buffered word.
- `out1_val`  out  1  out1 buffer holds a word.
- `out1_rdy`  in  1  consumer 1 accepts.
- `out1_msg`  out  NBITS  out1 buffered word.
- `cnt0`  out  8  count of words delivered on out0; wraps.
- `cnt1`  out  8  count of words delivered on out1; wraps.

Behaviour:
- **Reset:** one clock is used, and reset is synchronous and active-high (`rst` sampled on the `clk` rising edge). While `rst` is high at an edge:
  - `out0_val`, `out1_val` = 0
  - `out0_msg`, `out1_msg` = 0
  - `cnt0`, `cnt1` = 0
  - Buffered words are discarded, including mid-transfer.
  - `in_rdy` is forced to 0 during any cycle in which `rst` = 1.
- **Per-output buffer:** each output buffer has two states, EMPTY (`val` = 0) and FULL (`val` = 1).
- **Dequeue:** `outN` dequeues when `outN_val` && `outN_rdy`.
- **Input ready:** `in_rdy` = !`rst` && (buffer[`sel`] EMPTY || buffer[`sel`] dequeuing this cycle). This is combinational from `sel`, the target's `rdy` and state only. `in_rdy` does not depend on `in_val`.
- **Input transfer:** occurs when `in_val` && `in_rdy`.
  - The word is written into buffer[`sel`] at the next edge, and `outN_val` rises in the next cycle. Latency is 1 cycle.
  - The `sel` value used is the one present in the transfer cycle. `sel` has no effect in cycles without a transfer.
- **Buffer transitions:**
  - EMPTY + enqueue → FULL.
  - FULL + dequeue, no enqueue → EMPTY.
  - FULL + dequeue + enqueue in the same cycle → FULL with the new word (pass-through, no bubble).
  - FULL, no dequeue → hold.
- **Stability:** while `outN_val` = 1 && `outN_rdy` = 0, `outN_msg` holds stable. `outN_msg` is unchanged when a buffer empties; the stale value is don't-care when `val` = 0.
- **Blocking isolation:**
  - A blocked buffer stalls the input only when `sel` points at it.
  - Words to the other output keep flowing.
  - No reordering occurs within a single output. There is no ordering guarantee across outputs.
- **Simultaneous events:**
  - Dequeues on out0 and out1 may occur in the same cycle as an enqueue into either buffer.
  - Only one enqueue is possible per cycle.
- **Counters:**
  - `cntN` increments by 1 on each `outN` dequeue.
  - Both counters may increment in the same cycle.
  - 8-bit wrap: 255 → 0, with no saturation or flag.
- **Invalid input:** when `in_val` = 0, no state changes apart from dequeues.
- **X handling:** X on `in_msg` when `in_val` = 0 must not propagate to state.

Test Plan:
1. **Reset:** assert `rst` for 2 cycles with `in_val` = 1, `in_msg` = 8'hA5 → all `val` = 0, `msgs` = 0, `cnt0` = `cnt1` = 0, `in_rdy` = 0. After deassert, `in_rdy` = 1.
2. **Basic steering:** send 8'h11 with `sel` = 0, then 8'h22 with `sel` = 1, both consumers ready → `out0_msg` = 8'h11 one cycle after its transfer; `out1_msg` = 8'h22 the following cycle; `cnt0` = 1, `cnt1` = 1.
3. **Full-throughput pass-through:** `sel` = 0, `out0_rdy` = 1, stream 8'h01..8'h0A on consecutive cycles → `in_rdy` stays 1 throughout; out0 delivers 01..0A back-to-back in order; `cnt0` = 10.
4. **Backpressure isolation:**
   - Fill out0 with 8'h33 while `out0_rdy` = 0, then offer `sel` = 0 → `in_rdy` = 0, and `out0_msg` holds 8'h33.
   - Offer 8'h44 with `sel` = 1 → accepted; `out1_val` = 1 next cycle.
   - Raise `out0_rdy` → 8'h33 delivered once.
5. **Counter wrap:** deliver 256 words on out1 → `cnt1` reads 255 → 0; `cnt0` is unchanged.
6. **Reset mid-operation:** both buffers FULL (8'h55, 8'h66) with consumers stalled; pulse `rst` for 1 cycle → `val`s = 0, counters = 0, and neither word is ever delivered afterward.
